// File: rtl/div_ctrl_if.sv
// Bundle between the EX stage, the divide sequencer and the shared divider.
// The sequencer uses the slave view; whoever drives EX and the divider uses master.
interface div_ctrl_if #(
  parameter int DW = 32
);
  logic          req_valid_i;
  logic [1:0]    op_i;
  logic [DW-1:0] rs1_i;
  logic [DW-1:0] rs2_i;
  logic [4:0]    rd_i;
  logic          flush_i;
  logic          stall_o;
  logic          res_valid_o;
  logic [DW-1:0] res_data_o;
  logic [4:0]    res_rd_o;
  logic          err_timeout_o;
  logic          div_start_o;
  logic [DW-1:0] div_dividend_o;
  logic [DW-1:0] div_divisor_o;
  logic          div_signed_o;
  logic          div_busy_i;
  logic          div_done_i;
  logic [DW-1:0] div_quot_i;
  logic [DW-1:0] div_rem_i;

  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output stall_o, res_valid_o, res_data_o, res_rd_o, err_timeout_o,
    output div_start_o, div_dividend_o, div_divisor_o, div_signed_o,
    input  div_busy_i, div_done_i, div_quot_i, div_rem_i
  );

  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  stall_o, res_valid_o, res_data_o, res_rd_o, err_timeout_o,
    input  div_start_o, div_dividend_o, div_divisor_o, div_signed_o,
    output div_busy_i, div_done_i, div_quot_i, div_rem_i
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer between EX and the shared iterative divider for DIV/DIVU/REM/REMU.
// Divide-by-zero, signed overflow and repeated operand pairs are answered without the divider.
module div_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 48
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] INT_MIN  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          rem_q;
  logic          signed_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] dividend_q;
  logic [DW-1:0] divisor_q;
  logic [DW-1:0] res_q;
  logic          err_q;

  logic          cache_vld_q;
  logic          cache_sgn_q;
  logic [DW-1:0] cache_rs1_q;
  logic [DW-1:0] cache_rs2_q;
  logic [DW-1:0] cache_quot_q;
  logic [DW-1:0] cache_rem_q;

  logic          accept;
  logic          req_signed;
  logic          req_rem;
  logic          div_zero;
  logic          overflow;
  logic          cache_hit;
  logic          fast_path;
  logic [DW-1:0] fast_res;
  logic          in_flight;
  logic          capture;
  logic          tmo;

  assign req_signed = ~bus.op_i[0];
  assign req_rem    = bus.op_i[1];
  assign accept     = !rst && (state_q == IDLE) && bus.req_valid_i && !bus.flush_i;
  assign div_zero   = (bus.rs2_i == '0);
  assign overflow   = req_signed && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
  // The op type is not part of the tag: quotient and remainder are cached together.
  assign cache_hit  = cache_vld_q && (cache_rs1_q == bus.rs1_i) &&
                      (cache_rs2_q == bus.rs2_i) && (cache_sgn_q == req_signed);
  assign fast_path  = div_zero || overflow || cache_hit;

  always_comb begin
    fast_res = req_rem ? cache_rem_q : cache_quot_q;
    if (div_zero) begin
      fast_res = req_rem ? bus.rs1_i : '1;
    end else if (overflow) begin
      fast_res = req_rem ? '0 : bus.rs1_i;
    end
  end

  assign in_flight = (state_q == WAIT) || (state_q == DRAIN);
  assign capture   = in_flight && bus.div_done_i;
  assign tmo       = in_flight && !bus.div_done_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = fast_path ? DONE : ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        if (bus.flush_i)          state_d = IDLE;
        else if (!bus.div_busy_i) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A flush coinciding with completion needs no drain; the divider is already free.
        if (capture || tmo)    state_d = bus.flush_i ? IDLE : DONE;
        else if (bus.flush_i)  state_d = DRAIN;
      end
      DONE:  state_d = IDLE;
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (capture || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_o     = 1'b0;
    bus.res_valid_o = 1'b0;
    bus.div_start_o = 1'b0;
    case (state_q)
      IDLE:  bus.stall_o = accept;
      ISSUE: begin
        bus.stall_o     = 1'b1;
        bus.div_start_o = !bus.div_busy_i && !bus.flush_i;
      end
      WAIT:  bus.stall_o = 1'b1;
      DONE:  bus.res_valid_o = !bus.flush_i;
      DRAIN: bus.stall_o = bus.req_valid_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q      <= 1'b0;
      signed_q   <= 1'b0;
      rd_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        rem_q      <= req_rem;
        signed_q   <= req_signed;
        rd_q       <= bus.rd_i;
        dividend_q <= bus.rs1_i;
        divisor_q  <= bus.rs2_i;
        res_q      <= fast_res;
      end
      if (capture) res_q <= rem_q ? bus.div_rem_i : bus.div_quot_i;
      if (tmo) begin
        err_q <= 1'b1;
        res_q <= '0;
      end
    end
  end

  // Drained results still refresh the cache so a replayed op after a flush hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_sgn_q  <= 1'b0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_quot_q <= '0;
      cache_rem_q  <= '0;
    end else if (capture) begin
      cache_vld_q  <= 1'b1;
      cache_sgn_q  <= signed_q;
      cache_rs1_q  <= dividend_q;
      cache_rs2_q  <= divisor_q;
      cache_quot_q <= bus.div_quot_i;
      cache_rem_q  <= bus.div_rem_i;
    end
  end

  assign bus.res_data_o     = res_q;
  assign bus.res_rd_o       = rd_q;
  assign bus.err_timeout_o  = err_q;
  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;
  assign bus.div_signed_o   = signed_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a latency-programmable divider model plus an RV32M result/cache reference.
module tb_div_ctrl;
  localparam int DW      = 32;
  localparam int TIMEOUT = 48;

  logic clk;
  logic rst;

  div_ctrl_if #(.DW(DW)) bus ();

  div_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_end = 0;
  int dv_lat = 1;
  bit dv_hang = 0;
  int dv_starts = 0;

  bit          c_vld = 0;
  logic [31:0] c_a = 0;
  logic [31:0] c_b = 0;
  bit          c_sgn = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // RV32M semantics: /0 gives all-ones or the dividend, signed division truncates toward zero.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Divider: done arrives dv_lat cycles after the start cycle, unless dv_hang.
  initial begin : divider_model
    int          left;
    bit          pend;
    logic [31:0] q;
    logic [31:0] r;
    left = 0;
    pend = 0;
    q = 0;
    r = 0;
    bus.div_busy_i = 1'b0;
    bus.div_done_i = 1'b0;
    bus.div_quot_i = '0;
    bus.div_rem_i  = '0;
    forever begin
      @(negedge clk);
      bus.div_done_i = 1'b0;
      if (rst) begin
        pend = 0;
        left = 0;
      end
      if (pend) begin
        pend = 0;
        left = dv_lat;
      end
      if (left > 0) begin
        left--;
        if (left == 0 && !dv_hang) begin
          bus.div_done_i = 1'b1;
          bus.div_quot_i = q;
          bus.div_rem_i  = r;
        end
      end
      bus.div_busy_i = (left > 0) || (cyc < busy_end);
      #1;
      if (bus.div_start_o === 1'b1) begin
        pend = 1;
        dv_starts++;
        q = ref_res({1'b0, ~bus.div_signed_o}, bus.div_dividend_o, bus.div_divisor_o);
        r = ref_res({1'b1, ~bus.div_signed_o}, bus.div_dividend_o, bus.div_divisor_o);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int busy_cyc,
                        input int flush_at, input int drain_req_at, input bit hang);
    bit          sgn, fast, issue_flush, exp_start, got;
    logic [31:0] exp_d;
    int          exp_lat, st0, seen_lat;
    sgn = ~op[0];
    fast = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (c_vld && c_a == a && c_b == b && c_sgn == sgn);
    issue_flush = !fast && flush_at > 0 && flush_at <= busy_cyc + 1;
    exp_start = !fast && !issue_flush;
    exp_d = hang ? 32'h0 : ref_res(op, a, b);
    exp_lat = fast ? 1 : busy_cyc + (hang ? TIMEOUT : lat) + 2;
    seen_lat = 0;
    @(negedge clk);
    st0 = dv_starts;
    dv_lat = lat;
    dv_hang = hang;
    busy_end = cyc + 1 + busy_cyc;
    bus.req_valid_i = 1'b1;
    bus.op_i = op;
    bus.rs1_i = a;
    bus.rs2_i = b;
    bus.rd_i = rd;
    #1;
    chk("accept_stall", 32'(bus.stall_o), 32'd1);
    got = 0;
    for (int k = 1; k <= exp_lat + 8 && !got; k++) begin
      @(negedge clk);
      bus.req_valid_i = (k == drain_req_at);
      bus.flush_i = (k == flush_at);
      #1;
      if (drain_req_at > 0 && k == drain_req_at) chk("drain_req_stall", 32'(bus.stall_o), 32'd1);
      if (drain_req_at > 0 && k == drain_req_at + 1) chk("drain_stall", 32'(bus.stall_o), 32'd0);
      if (bus.res_valid_o === 1'b1) begin
        got = 1;
        seen_lat = k;
        if (flush_at == 0) begin
          chk("res_data", bus.res_data_o, exp_d);
          chk("res_rd", 32'(bus.res_rd_o), 32'(rd));
          chk("latency", k, exp_lat);
          chk("done_stall", 32'(bus.stall_o), 32'd0);
        end
      end
    end
    bus.req_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("res_seen", 32'(got), 32'(flush_at == 0));
    chk("start_count", dv_starts - st0, 32'(exp_start));
    if (exp_start && !hang) begin
      c_vld = 1;
      c_a = a;
      c_b = b;
      c_sgn = sgn;
    end
    $display("op=%0d a=0x%08h b=0x%08h rd=%0d flush=%0d -> res=0x%08h lat=%0d starts=%0d",
             op, a, b, rd, flush_at, bus.res_data_o, seen_lat, dv_starts - st0);
  endtask

  initial begin : stimulus
    logic [31:0] pa, pb, ra, rb;
    logic [1:0]  rop;
    pa = 32'd100;
    pb = 32'd7;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i = 2'b00;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.rd_i = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("rst_res_data", bus.res_data_o, 32'd0);
    chk("rst_err", 32'(bus.err_timeout_o), 32'd0);
    chk("rst_start", 32'(bus.div_start_o), 32'd0);
    chk("rst_dividend", bus.div_dividend_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // DIVU then REMU on the same operands: the second must come from the cache.
    run_op(2'b01, 32'd100, 32'd7, 5'd3, 5, 2, 0, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 5'd4, 5, 0, 0, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 5, 0, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 5, 0, 0, 0, 0);
    run_op(2'b01, 32'd5, 32'd0, 5'd7, 5, 0, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd8, 5, 0, 0, 0, 0);

    // Flush in WAIT with a blocked request during DRAIN, then cache replay.
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9, 6, 0, 3, 4, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd10, 6, 0, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd11, 6, 0, 0, 0, 0);

    // Flush in ISSUE, then the real op; flush in DONE on the cached remainder.
    run_op(2'b01, 32'd1000, 32'd3, 5'd12, 4, 3, 2, 0, 0);
    run_op(2'b01, 32'd1000, 32'd3, 5'd13, 4, 2, 0, 0, 0);
    run_op(2'b11, 32'd1000, 32'd3, 5'd14, 4, 0, 1, 0, 0);

    // Divider never answers.
    run_op(2'b01, 32'd77, 32'd5, 5'd15, 5, 0, 0, 0, 1);
    chk("err_timeout_set", 32'(bus.err_timeout_o), 32'd1);
    run_op(2'b01, 32'd77, 32'd5, 5'd16, 3, 0, 0, 0, 0);
    chk("err_timeout_sticky", 32'(bus.err_timeout_o), 32'd1);

    // Asynchronous reset while the divider is running.
    @(negedge clk);
    dv_lat = 12;
    dv_hang = 0;
    bus.req_valid_i = 1'b1;
    bus.op_i = 2'b00;
    bus.rs1_i = 32'd1234;
    bus.rs2_i = 32'hFFFF_FFFB;
    bus.rd_i = 5'd17;
    #1;
    chk("rstwait_accept", 32'(bus.stall_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait_stall", 32'(bus.stall_o), 32'd0);
    chk("rstwait_err", 32'(bus.err_timeout_o), 32'd0);
    chk("rstwait_res_data", bus.res_data_o, 32'd0);
    chk("rstwait_res_rd", 32'(bus.res_rd_o), 32'd0);
    chk("rstwait_dividend", bus.div_dividend_o, 32'd0);
    chk("rstwait_divisor", bus.div_divisor_o, 32'd0);
    chk("rstwait_signed", 32'(bus.div_signed_o), 32'd0);
    c_vld = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(2'b01, 32'd77, 32'd5, 5'd18, 3, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin ra = pa; rb = pb; end
        1: begin ra = $urandom; rb = 32'h0; end
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: begin
          ra = $urandom;
          rb = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 100)) : $urandom;
        end
      endcase
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), int'($urandom_range(1, 8)),
             int'($urandom_range(0, 3)), 0, 0, 0);
      pa = ra;
      pb = rb;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
